// File: rtl/montgomery_reduce_scheduler_if.sv
// montgomery_reduce_scheduler_if: requester, reducer and constant-ROM signals around the shared reducer
interface montgomery_reduce_scheduler_if #(
  parameter int REGISTER_SIZE = 32,
  parameter int R = 4096
);
  localparam int NC = R / REGISTER_SIZE;
  localparam int AW = $clog2(NC);
  logic [1:0] req_in;
  logic [1:0] grant_out;
  logic [1:0] t_ready_out;
  logic t0_valid_in;
  logic [REGISTER_SIZE-1:0] t0_block_in;
  logic t1_valid_in;
  logic [REGISTER_SIZE-1:0] t1_block_in;
  logic red_valid_out;
  logic [REGISTER_SIZE-1:0] red_T_block_out;
  logic consumed_k_in;
  logic consumed_N_in;
  logic [AW-1:0] k_rom_addr_out;
  logic [AW-1:0] N_rom_addr_out;
  logic red_valid_in;
  logic [REGISTER_SIZE-1:0] red_data_in;
  logic red_final_in;
  logic [1:0] res_valid_out;
  logic [REGISTER_SIZE-1:0] res_block_out;
  logic busy_out;
  logic overflow_out;
  modport slave (
    input req_in, t0_valid_in, t0_block_in, t1_valid_in, t1_block_in,
    input consumed_k_in, consumed_N_in, red_valid_in, red_data_in, red_final_in,
    output grant_out, t_ready_out, red_valid_out, red_T_block_out,
    output k_rom_addr_out, N_rom_addr_out, res_valid_out, res_block_out, busy_out, overflow_out
  );
  modport master (
    output req_in, t0_valid_in, t0_block_in, t1_valid_in, t1_block_in,
    output consumed_k_in, consumed_N_in, red_valid_in, red_data_in, red_final_in,
    input grant_out, t_ready_out, red_valid_out, red_T_block_out,
    input k_rom_addr_out, N_rom_addr_out, res_valid_out, res_block_out, busy_out, overflow_out
  );
endinterface

// File: rtl/montgomery_reduce_scheduler.sv
// montgomery_reduce_scheduler: round-robin sharing of one Montgomery reducer between two requesters
module montgomery_reduce_scheduler #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS = 256,
  parameter int R = 4096
) (
  input logic clk_in,
  input logic rst_in,
  montgomery_reduce_scheduler_if.slave bus
);
  localparam int NC = R / REGISTER_SIZE;
  localparam int AW = $clog2(NC);
  localparam int CW = $clog2(NUM_BLOCKS);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] FEED = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;
  logic [1:0] state;
  logic [1:0] grant;
  logic last_served;
  logic done_q;
  logic [CW-1:0] cnt;
  logic [AW-1:0] k_idx;
  logic [AW-1:0] n_idx;
  logic [AW-1:0] k_addr;
  logic [AW-1:0] n_addr;
  logic g_valid;
  logic [REGISTER_SIZE-1:0] g_block;
  logic accept;
  logic last_blk;
  logic start;
  logic [1:0] pick;
  logic route;
  logic red_valid;
  logic [REGISTER_SIZE-1:0] red_block;
  logic [1:0] res_valid;
  logic [REGISTER_SIZE-1:0] res_block;
  logic overflow;
  // Select the owner's T stream, arbitration choice and next constant addresses
  always_comb begin
    g_valid = grant[1] ? bus.t1_valid_in : grant[0] & bus.t0_valid_in;
    g_block = grant[1] ? bus.t1_block_in : bus.t0_block_in;
    accept = state == FEED && g_valid;
    last_blk = cnt == CW'(NUM_BLOCKS - 1);
    start = state == IDLE && bus.req_in != 2'b00;
    pick = bus.req_in == 2'b11 ? (last_served ? 2'b01 : 2'b10) : bus.req_in;
    route = state == DRAIN && bus.red_valid_in;
    k_addr = bus.consumed_k_in ? (k_idx == AW'(NC - 1) ? '0 : k_idx + AW'(1)) : k_idx;
    n_addr = bus.consumed_N_in ? (n_idx == AW'(NC - 1) ? '0 : n_idx + AW'(1)) : n_idx;
  end
  // Job sequencing: arbitrate, count accepted T blocks, release on the reducer's final block
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      grant <= 2'b00;
      last_served <= 1'b1;
      cnt <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= accept && last_blk;
      case (state)
        IDLE: if (start) begin
          grant <= pick;
          cnt <= '0;
          state <= GRANT;
        end
        GRANT: state <= FEED;
        FEED: if (accept) begin
          cnt <= last_blk ? '0 : cnt + CW'(1);
          state <= last_blk ? DRAIN : FEED;
        end
        default: if (bus.red_final_in) begin
          grant <= 2'b00;
          last_served <= grant[1];
          state <= IDLE;
        end
      endcase
    end
  end
  // Constant pointers follow the presented address; a new job restarts both at block 0
  always_ff @(posedge clk_in) begin
    if (rst_in || start) begin
      k_idx <= '0;
      n_idx <= '0;
    end else begin
      k_idx <= k_addr;
      n_idx <= n_addr;
    end
  end
  // Forward owner T blocks, route reducer output back to the owner, flag excess T blocks
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      red_valid <= 1'b0;
      red_block <= '0;
      res_valid <= 2'b00;
      res_block <= '0;
      overflow <= 1'b0;
    end else begin
      red_valid <= accept;
      if (accept) red_block <= g_block;
      res_valid <= route ? grant : 2'b00;
      if (route) res_block <= bus.red_data_in;
      if (done_q && g_valid) overflow <= 1'b1;
    end
  end
  assign bus.grant_out = grant;
  assign bus.t_ready_out = state == FEED ? grant : 2'b00;
  assign bus.red_valid_out = red_valid;
  assign bus.red_T_block_out = red_block;
  assign bus.k_rom_addr_out = k_addr;
  assign bus.N_rom_addr_out = n_addr;
  assign bus.res_valid_out = res_valid;
  assign bus.res_block_out = res_block;
  assign bus.busy_out = state != IDLE;
  assign bus.overflow_out = overflow;
endmodule
